// File: rtl/pu_operand_loader_pkg.sv
// Shared definitions for the pu operand loader: FSM state encoding and the
// default operand geometry of the pu datapath it feeds.
package pu_operand_loader_pkg;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    WAIT   = 2'd1,
    RESULT = 2'd2
  } state_t;

  localparam int PU_WIDTH = 5;
  localparam int PU_N     = 4;

endpackage

// File: rtl/n_bit_reg.sv
// Generic load-enabled register with asynchronous active-low clear; used for
// every operand slot and for the captured result.
module n_bit_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/pu_operand_loader.sv
// Streams 2N operand words into parallel x/w slots for one pu, waits the pu
// latency, then offers the captured pu result downstream.
module pu_operand_loader
  import pu_operand_loader_pkg::*;
#(
  parameter int WIDTH      = PU_WIDTH,
  parameter int N          = PU_N,
  parameter int PU_LATENCY = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [N*WIDTH-1:0] pu_x,
  output logic [N*WIDTH-1:0] pu_w,
  input  logic [WIDTH-1:0]   pu_out,
  output logic [WIDTH-1:0]   res_data,
  output logic               res_valid,
  input  logic               res_ready,
  output logic               busy,
  output state_t             dbg_state
);

  localparam int BW = (2 * N > 1) ? $clog2(2 * N) : 1;
  localparam int CW = $clog2(PU_LATENCY) + 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(2 * N - 1);

  state_t          state;
  logic [BW-1:0]   beat;
  logic [CW-1:0]   wait_cnt;
  logic            accept;
  logic            capture;

  // Both ports use the same handshake: a word/result moves on a rising edge
  // where valid and ready are both high; valid must hold its data until then,
  // and ready never depends combinationally on valid.
  assign in_ready  = (state == LOAD);
  assign accept    = in_valid && in_ready;
  assign capture   = (state == WAIT) && (wait_cnt == '0);
  assign busy      = (state != LOAD) || (beat != '0);
  assign dbg_state = state;

  for (genvar k = 0; k < N; k++) begin : g_slot
    n_bit_reg #(.W(WIDTH)) u_x (
      .clk (clk),
      .rst (rst),
      .en  (accept && (beat == BW'(k))),
      .d   (in_data),
      .q   (pu_x[k*WIDTH +: WIDTH])
    );
    n_bit_reg #(.W(WIDTH)) u_w (
      .clk (clk),
      .rst (rst),
      .en  (accept && (beat == BW'(N + k))),
      .d   (in_data),
      .q   (pu_w[k*WIDTH +: WIDTH])
    );
  end

  // pu_out is sampled on the edge that ends the final WAIT cycle.
  n_bit_reg #(.W(WIDTH)) u_res (
    .clk (clk),
    .rst (rst),
    .en  (capture),
    .d   (pu_out),
    .q   (res_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= LOAD;
      beat      <= '0;
      wait_cnt  <= '0;
      res_valid <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          if (accept) begin
            if (beat == LAST_BEAT) begin
              beat     <= '0;
              wait_cnt <= CW'(PU_LATENCY - 1);
              state    <= WAIT;
            end else begin
              beat <= beat + 1'b1;
            end
          end
        end
        WAIT: begin
          if (wait_cnt == '0) begin
            res_valid <= 1'b1;
            state     <= RESULT;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        RESULT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= LOAD;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_pu_operand_loader.sv
// Directed bench for pu_operand_loader with a stub pu that returns x0+w0,
// plus a second instance built with a one-cycle pu latency.
module tb_pu_operand_loader;
  import pu_operand_loader_pkg::*;

  localparam int WIDTH = 5;
  localparam int N     = 4;
  localparam int LAT   = 2;

  typedef logic [WIDTH-1:0] stream_t [2*N];

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- main DUT (PU_LATENCY=2) ----------------
  logic [WIDTH-1:0]   in_data;
  logic               in_valid;
  logic               in_ready;
  logic [N*WIDTH-1:0] pu_x;
  logic [N*WIDTH-1:0] pu_w;
  logic [WIDTH-1:0]   pu_out;
  logic [WIDTH-1:0]   res_data;
  logic               res_valid;
  logic               res_ready;
  logic               busy;
  state_t             dbg_state;
  logic [WIDTH-1:0]   stub_s1;

  pu_operand_loader #(.WIDTH(WIDTH), .N(N), .PU_LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .pu_x(pu_x), .pu_w(pu_w), .pu_out(pu_out),
    .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready),
    .busy(busy), .dbg_state(dbg_state)
  );

  // Stub pu: (x0 + w0) mod 32 through a two-stage pipeline.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stub_s1 <= '0;
      pu_out  <= '0;
    end else begin
      stub_s1 <= pu_x[WIDTH-1:0] + pu_w[WIDTH-1:0];
      pu_out  <= stub_s1;
    end
  end

  // ---------------- second DUT (PU_LATENCY=1) ----------------
  logic [WIDTH-1:0]   l1_in_data;
  logic               l1_in_valid;
  logic               l1_in_ready;
  logic [N*WIDTH-1:0] l1_pu_x;
  logic [N*WIDTH-1:0] l1_pu_w;
  logic [WIDTH-1:0]   l1_pu_out;
  logic [WIDTH-1:0]   l1_res_data;
  logic               l1_res_valid;
  logic               l1_res_ready;
  logic               l1_busy;
  state_t             l1_dbg_state;

  pu_operand_loader #(.WIDTH(WIDTH), .N(N), .PU_LATENCY(1)) dut_l1 (
    .clk(clk), .rst(rst), .in_data(l1_in_data), .in_valid(l1_in_valid),
    .in_ready(l1_in_ready), .pu_x(l1_pu_x), .pu_w(l1_pu_w), .pu_out(l1_pu_out),
    .res_data(l1_res_data), .res_valid(l1_res_valid), .res_ready(l1_res_ready),
    .busy(l1_busy), .dbg_state(l1_dbg_state)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) l1_pu_out <= '0;
    else      l1_pu_out <= l1_pu_x[WIDTH-1:0] + l1_pu_w[WIDTH-1:0];
  end

  // ---------------- scoreboard ----------------
  logic [WIDTH-1:0] exp_q[$];
  int tests = 0;
  int fails = 0;
  bit busy_low_seen;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_stream(input stream_t s, input bit bubbles, input int nbeats);
    int guard;
    bit acc;
    logic [WIDTH-1:0] sum;
    for (int i = 0; i < nbeats; i++) begin
      if (bubbles && i > 0) begin
        in_valid = 1'b0;
        tick();
        if (!busy) busy_low_seen = 1'b1;
      end
      in_valid = 1'b1;
      in_data  = s[i];
      guard    = 0;
      do begin
        acc = in_ready;
        tick();
        guard++;
      end while (!acc && guard < 50);
      if (!acc) check("accept_timeout", 32'(acc), 32'd1);
      if (!busy) busy_low_seen = 1'b1;
    end
    in_valid = 1'b0;
    if (nbeats == 2 * N) begin
      sum = s[0] + s[N];
      exp_q.push_back(sum);
    end
  endtask

  task automatic wait_result(input string tag, input int lat);
    int cycles;
    cycles = 0;
    while (!res_valid && cycles < 50) begin
      tick();
      cycles++;
      if (!busy) busy_low_seen = 1'b1;
    end
    check(tag, 32'(cycles), 32'(lat));
  endtask

  task automatic take_result(input string tag);
    logic [WIDTH-1:0] e;
    check({tag, "_sb_depth"}, 32'(exp_q.size()), 32'd1);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    check({tag, "_data"}, 32'(res_data), 32'(e));
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    in_valid  = 1'b0;
    check({tag, "_valid_drop"}, 32'(res_valid), 32'd0);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_state"}, 32'(dbg_state), 32'(LOAD));
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic check_slots(input string tag, input stream_t s);
    logic [N*WIDTH-1:0] ex;
    logic [N*WIDTH-1:0] ew;
    for (int k = 0; k < N; k++) begin
      ex[k*WIDTH +: WIDTH] = s[k];
      ew[k*WIDTH +: WIDTH] = s[N+k];
    end
    check({tag, "_pu_x"}, 32'(pu_x), 32'(ex));
    check({tag, "_pu_w"}, 32'(pu_w), 32'(ew));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    stream_t s_a, s_b, s_c, s_d;
    bit bp_ok;
    bit l1_ok;
    int cycles;
    s_a = '{5'd4, 5'd6, 5'd2, 5'd1, 5'd8, 5'd2, 5'd2, 5'd2};
    s_b = '{5'd31, 5'd31, 5'd31, 5'd31, 5'd1, 5'd1, 5'd1, 5'd1};
    s_c = '{5'd7, 5'd3, 5'd5, 5'd9, 5'd11, 5'd13, 5'd17, 5'd19};
    s_d = '{5'd10, 5'd20, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8};

    rst = 1'b0;
    in_valid = 1'b0; in_data = '0; res_ready = 1'b0;
    l1_in_valid = 1'b0; l1_in_data = '0; l1_res_ready = 1'b0;
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_res_data", 32'(res_data), 32'd0);
    check("rst_pu_x", 32'(pu_x), 32'd0);
    check("rst_pu_w", 32'(pu_w), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(LOAD));
    #1 rst = 1'b1;
    tick();

    // Single transaction, continuous stream.
    send_stream(s_a, 1'b0, 2 * N);
    check_slots("t1", s_a);
    wait_result("t1_latency", LAT);
    take_result("t1");

    // Bubbles every other cycle.
    busy_low_seen = 1'b0;
    send_stream(s_a, 1'b1, 2 * N);
    check_slots("t2", s_a);
    wait_result("t2_latency", LAT);
    check("t2_busy_held", 32'(busy_low_seen), 32'd0);
    take_result("t2");

    // Result backpressure with a word offered that must not be consumed.
    send_stream(s_a, 1'b0, 2 * N);
    wait_result("t3_latency", LAT);
    in_valid = 1'b1;
    in_data  = 5'd9;
    bp_ok    = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (res_data !== 5'd12 || in_ready !== 1'b0 || res_valid !== 1'b1) bp_ok = 1'b0;
    end
    check("t3_stall", 32'(bp_ok), 32'd1);
    take_result("t3");
    check_slots("t3_unconsumed", s_a);

    // Back-to-back transactions.
    send_stream(s_a, 1'b0, 2 * N);
    wait_result("t4a_latency", LAT);
    take_result("t4a");
    send_stream(s_b, 1'b0, 2 * N);
    check_slots("t4b", s_b);
    wait_result("t4b_latency", LAT);
    take_result("t4b");

    // Reset after five beats.
    send_stream(s_c, 1'b0, 5);
    check("t5_busy_partial", 32'(busy), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("t5_pu_x", 32'(pu_x), 32'd0);
    check("t5_pu_w", 32'(pu_w), 32'd0);
    check("t5_in_ready", 32'(in_ready), 32'd1);
    check("t5_busy", 32'(busy), 32'd0);
    #2 rst = 1'b1;
    tick();
    send_stream(s_d, 1'b0, 2 * N);
    check_slots("t5", s_d);
    wait_result("t5_latency", LAT);
    take_result("t5");

    // PU_LATENCY=1 instance.
    l1_ok = 1'b1;
    l1_in_valid = 1'b1;
    for (int i = 0; i < 2 * N; i++) begin
      l1_in_data = s_a[i];
      if (l1_in_ready !== 1'b1) l1_ok = 1'b0;
      tick();
    end
    l1_in_valid = 1'b0;
    check("t6_accepts", 32'(l1_ok), 32'd1);
    cycles = 0;
    while (!l1_res_valid && cycles < 50) begin
      tick();
      cycles++;
    end
    check("t6_latency", 32'(cycles), 32'd1);
    check("t6_data", 32'(l1_res_data), 32'd12);
    l1_res_ready = 1'b1;
    tick();
    l1_res_ready = 1'b0;
    check("t6_valid_drop", 32'(l1_res_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pu_operand_loader.md
# pu_operand_loader

Streaming front end for the processing unit `pu`, on the producer side of its operand interface. It accepts a serial stream of WIDTH-bit operand words over a valid/ready handshake and assembles them into N inputs (x) and N weights (w). It presents the assembled operands to `pu` in parallel, waits a fixed PU latency, captures `pu` output and offers it downstream over a second valid/ready handshake. It sits between the operand source (memory or bench) and one `pu` instance.

## Interface
- WIDTH, 5, operand and result word width (matches `pu`)
- N, 4, number of x/w operand pairs per transaction
- PU_LATENCY, 2, clock cycles from stable operands to valid `pu` output; legal range ≥1
- clk  input  1  rising-edge clock
- rst  input  1  reset, asynchronous, active-low
- in_data  input  WIDTH  operand word
- in_valid  input  1  source has a word
- in_ready  output  1  loader accepts a word this cycle
- pu_x  output  N*WIDTH  x operands; slot k at bits [k*WIDTH +: WIDTH]
- pu_w  output  N*WIDTH  weight operands; same packing
- pu_out  input  WIDTH  `pu` result
- res_data  output  WIDTH  captured result
- res_valid  output  1  result available
- res_ready  input  1  sink accepts result
- busy  output  1  a transaction is in progress

## Operation
- One clock (`clk`); `rst` is asynchronous and active-low. All state clears immediately on `rst`=0.
- Reset values:
  - in_ready=1, res_valid=0, res_data=0, pu_x=0, pu_w=0, busy=0
  - state=LOAD, beat counter=0, wait counter=0
- FSM states LOAD, WAIT and RESULT:
  - LOAD: in_ready=1. A beat is accepted on in_valid&in_ready. Beat index b runs 0..2N-1.
    - b<N writes x slot b.
    - b≥N writes w slot b−N.
    - Acceptance of beat 2N-1 moves to WAIT, loads the wait counter with PU_LATENCY-1, and resets b to 0.
  - WAIT: in_ready=0. The counter decrements each cycle. At count 0, res_data←pu_out, res_valid←1, and the state moves to RESULT.
  - RESULT: in_ready=0, res_valid=1, res_data held. On res_valid&res_ready the state moves to LOAD and res_valid←0.
- Operand registers are never cleared except by reset. Each slot holds its value until overwritten by the next transaction.
- pu_x/pu_w change only on accepted beats. They are stable for the whole WAIT and RESULT period.
- busy=1 when state≠LOAD or b≠0.
- Counter widths:
  - Beat counter: clog2(2N) bits, no wrap past 2N-1.
  - Wait counter: clog2(PU_LATENCY)+1 bits.
- The loader does no arithmetic on data; words are transported bit-exact.

## Timing
- Throughput: one beat per cycle in LOAD. in_valid held high gives 2N consecutive accepts.
- Latency: res_valid rises exactly PU_LATENCY cycles after the edge that accepts beat 2N-1.
- res_data is sampled from pu_out on the edge ending the last WAIT cycle.
- Back-to-back: the edge that accepts the result returns to LOAD. in_ready is 1 in the following cycle, so there is one cycle gap from result handshake to first new beat.
- A word offered (in_valid=1) while in_ready=0 is not consumed. The source must hold it.
- res_ready asserted before res_valid has no effect.
- res_ready low stalls RESULT indefinitely with res_data stable.
- in_valid toggling mid-LOAD: gaps are allowed, b holds, and partial slots keep prior values.
- Reset mid-transaction (any state) aborts immediately. The next beat after release is b=0 (slot x0).

## Structure
- Shared package: state encoding constants LOAD/WAIT/RESULT and the default WIDTH and N used by `pu`.
- Reuse the existing `n_bit_reg` as the sub-module for each operand slot and for the result register. Its load enable is driven from the beat decode and capture strobe.
- FSM, beat counter and wait counter live in the top module. No other sub-modules.

## Test plan
- Reset then single transaction:
  - Stub `pu` with pu_out = (x0+w0) mod 32, registered PU_LATENCY=2.
  - Stream 4,6,2,1,8,2,2,2 with in_valid continuous.
  - Required: pu_x slots = 4,6,2,1; pu_w slots = 8,2,2,2; res_valid exactly 2 cycles after the 8th accept; res_data=12.
- Bubbles:
  - Same stream with in_valid low every other cycle.
  - Required: identical slots and result; busy high from the first accept to the result handshake.
- Backpressure:
  - Hold res_ready=0 for 10 cycles after res_valid.
  - Required: res_data=12 stable, in_ready=0 throughout, stream words not consumed; on res_ready=1, LOAD with in_ready=1 next cycle.
- Back-to-back:
  - Two transactions, the second being 31 ×4, 1 ×4.
  - Required: second res_data=0 (31+1 wraps mod 32); first-transaction slots fully overwritten.
- Reset mid-LOAD:
  - Assert rst=0 after 5 beats.
  - Required: immediately pu_x=pu_w=0, in_ready=1, busy=0; the next stream loads from slot x0.
- PU_LATENCY=1 build:
  - Required: res_valid 1 cycle after the last accept.
